universal_register: RTL
=======================

# universal_register

Parametrised multi-mode register for the MiniCPU datapath, generalising the fixed 8-bit load/clear register. It holds one WIDTH-bit word and, under a mode select, can hold, parallel-load, shift, rotate, increment or decrement it. It reports a registered carry/borrow flag and a zero flag. It serves as accumulator, shift register or loop counter in the CPU.

## Interface
- WIDTH, 8, data width in bits; legal range 2 to 32.
- RESET_VAL, 0, value loaded into Qout by RST_N; WIDTH bits.
- SATURATE, 0, when 1 INC/DEC saturate instead of wrapping.

- CLK  in  1  clock; all state updates on rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- CLR  in  1  synchronous clear, active-high.
- EN  in  1  operation enable.
- MODE  in  3  operation select (see Operation).
- D  in  WIDTH  parallel load data.
- SIN  in  1  serial input for SHL/SHR.
- Qout  out  WIDTH  register contents.
- CO  out  1  registered carry/borrow/shift-out flag.
- ZERO  out  1  high when Qout == 0; combinational from Qout.

## Operation
- Priority: RST_N low > CLR > EN low > MODE.
- RST_N low: Qout = RESET_VAL and CO = 0 immediately, independent of CLK.
- CLR high at edge: Qout = 0 and CO = 0, regardless of EN. This is a deliberate change from the previous register, where clear was gated by enable.
- EN low, CLR low: Qout and CO hold.
- EN high, MODE:
  - 000 HOLD: Qout holds; CO holds.
  - 001 LOAD: Qout = D; CO = 0.
  - 010 SHL: Qout = {Qout[W-2:0], SIN}; CO = old Qout[W-1].
  - 011 SHR: Qout = {SIN, Qout[W-1:1]}; CO = old Qout[0].
  - 100 ROL: Qout = {Qout[W-2:0], Qout[W-1]}; CO = old Qout[W-1].
  - 101 ROR: Qout = {Qout[0], Qout[W-1:1]}; CO = old Qout[0].
  - 110 INC:
    - Qout = Qout + 1, modulo 2^WIDTH.
    - CO = 1 only when old Qout was all-ones; otherwise 0.
  - 111 DEC:
    - Qout = Qout - 1, modulo 2^WIDTH.
    - CO = 1 only when old Qout was 0 (borrow); otherwise 0.
- SATURATE = 1:
  - INC at all-ones: Qout stays all-ones; CO = 1.
  - DEC at 0: Qout stays 0; CO = 1.
  - All other modes are unaffected.
- Arithmetic is unsigned, WIDTH+1-bit internally; the MSB of the internal result is CO for INC.
- D and SIN are ignored in modes other than LOAD and SHL/SHR respectively.

## Timing
- Latency: one cycle. A mode applied with EN high before edge k is visible on Qout/CO after edge k.
- ZERO tracks Qout combinationally, with no added latency.
- Back-to-back operations every cycle; no stall or handshake.
- Reset assert mid-operation: outputs go to reset values asynchronously. An in-flight operation at that edge is discarded.
- Reset release: the first rising edge with RST_N high executes normally. Deassertion must be synchronised to CLK externally.
- CLR and EN both high with any MODE: the clear wins.
- Reset values: Qout = RESET_VAL, CO = 0, ZERO = (RESET_VAL == 0).

## Structure
- Shared package `minicpu_pkg`:
  - MODE encodings as named constants MODE_HOLD through MODE_DEC.
  - MODE width constant (3).
- Sub-module `universal_register_next`: purely combinational next-state/next-CO unit taking Qout, D, SIN, MODE and SATURATE.
- The top level holds only the flops, the priority logic (RST_N/CLR/EN) and ZERO.

## Test plan
All scenarios use WIDTH=8, RESET_VAL=0 unless stated.

- Reset: RST_N low between clock edges -> Qout=00 and CO=0 immediately. RESET_VAL=A5 build -> Qout=A5 and ZERO=0.
- Load/clear/enable:
  - LOAD D=3C -> Qout=3C, ZERO=0.
  - EN=0 with MODE=LOAD, D=FF -> Qout stays 3C.
  - CLR=1 with EN=0 -> Qout=00, CO=0, ZERO=1.
- Shift/rotate from Qout=81:
  - SHL SIN=0 -> 02, CO=1.
  - ROR -> 01, CO=0.
  - ROR -> 80, CO=1.
  - SHR SIN=1 -> C0, CO=0.
- Wrap counting (SATURATE=0):
  - From FE, INC -> FF (CO=0), then INC -> 00 (CO=1, ZERO=1).
  - DEC -> FF with CO=1.
- Saturating build (SATURATE=1):
  - INC at FF -> FF, CO=1.
  - DEC at 00 -> 00, CO=1.
  - DEC at 05 -> 04, CO=0.
- Priority and mid-operation reset:
  - CLR=1, EN=1, MODE=INC at 7F -> 00.
  - RST_N pulsed low during a stream of INCs -> 00 at once; counting resumes 00->01 on the first edge after release.

Source files
------------

// File: rtl/minicpu_pkg.sv
// Shared MiniCPU definitions: operation-select encodings for the universal register.
package minicpu_pkg;

    localparam int MODE_W = 3;

    typedef enum logic [MODE_W-1:0] {
        MODE_HOLD = 3'b000,
        MODE_LOAD = 3'b001,
        MODE_SHL  = 3'b010,
        MODE_SHR  = 3'b011,
        MODE_ROL  = 3'b100,
        MODE_ROR  = 3'b101,
        MODE_INC  = 3'b110,
        MODE_DEC  = 3'b111
    } mode_e;

endpackage

// File: rtl/universal_register_next.sv
// Combinational next-value and next-flag unit for the universal register.
module universal_register_next
    import minicpu_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int SATURATE = 0
) (
    input  logic [WIDTH-1:0]  q,
    input  logic              co,
    input  logic [WIDTH-1:0]  d,
    input  logic              sin,
    input  logic [MODE_W-1:0] mode,
    output logic [WIDTH-1:0]  q_next,
    output logic              co_next
);

    // Arithmetic is one bit wider so the top bit is the carry (INC) or borrow (DEC).
    logic [WIDTH:0] inc_sum;
    logic [WIDTH:0] dec_diff;

    assign inc_sum  = {1'b0, q} + {{WIDTH{1'b0}}, 1'b1};
    assign dec_diff = {1'b0, q} - {{WIDTH{1'b0}}, 1'b1};

    always_comb begin
        // NOTE: defaults first so every path assigns every output and no latch is inferred.
        q_next  = q;
        co_next = co;
        case (mode_e'(mode))
            MODE_HOLD: begin
                q_next  = q;
                co_next = co;
            end
            MODE_LOAD: begin
                q_next  = d;
                co_next = 1'b0;
            end
            MODE_SHL: begin
                q_next  = {q[WIDTH-2:0], sin};
                co_next = q[WIDTH-1];
            end
            MODE_SHR: begin
                q_next  = {sin, q[WIDTH-1:1]};
                co_next = q[0];
            end
            MODE_ROL: begin
                q_next  = {q[WIDTH-2:0], q[WIDTH-1]};
                co_next = q[WIDTH-1];
            end
            MODE_ROR: begin
                q_next  = {q[0], q[WIDTH-1:1]};
                co_next = q[0];
            end
            MODE_INC: begin
                co_next = inc_sum[WIDTH];
                q_next  = (SATURATE != 0 && inc_sum[WIDTH]) ? q : inc_sum[WIDTH-1:0];
            end
            MODE_DEC: begin
                co_next = dec_diff[WIDTH];
                q_next  = (SATURATE != 0 && dec_diff[WIDTH]) ? q : dec_diff[WIDTH-1:0];
            end
            default: begin
                q_next  = q;
                co_next = co;
            end
        endcase
    end

endmodule

// File: rtl/universal_register.sv
// Multi-mode WIDTH-bit register (hold/load/shift/rotate/inc/dec) with carry and zero flags.
module universal_register
    import minicpu_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter int               SATURATE  = 0
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              CLR,
    input  logic              EN,
    input  logic [MODE_W-1:0] MODE,
    input  logic [WIDTH-1:0]  D,
    input  logic              SIN,
    output logic [WIDTH-1:0]  Qout,
    output logic              CO,
    output logic              ZERO
);

    logic [WIDTH-1:0] q_next;
    logic             co_next;

    universal_register_next #(
        .WIDTH    (WIDTH),
        .SATURATE (SATURATE)
    ) u_next (
        .q       (Qout),
        .co      (CO),
        .d       (D),
        .sin     (SIN),
        .mode    (MODE),
        .q_next  (q_next),
        .co_next (co_next)
    );

    // Clear deliberately ignores EN, unlike the older load/clear register.
    always_ff @(posedge CLK or negedge RST_N) begin
        // NOTE: non-blocking assignments for flops so all state updates see pre-edge values.
        if (!RST_N) begin
            Qout <= RESET_VAL;
            CO   <= 1'b0;
        end else if (CLR) begin
            Qout <= '0;
            CO   <= 1'b0;
        end else if (EN) begin
            Qout <= q_next;
            CO   <= co_next;
        end
    end

    assign ZERO = (Qout == '0);

endmodule
